sw_seq_streamer: RTL and testbench

Host-side transmitter for the Smith-Waterman core's 2-bit symbol stream. Buffers a query and a database sequence written by the host, serialises them onto the core's `Read_en`/`data_readin` inputs with the frame encoding below, then waits for the core's `valid` and returns `max_result`. It sits between the host/bench and `SW_Control_v3`, replacing file-driven stimulus.

---
 rtl/sw_pkg.sv | 31 +++
 rtl/sw_sym_buffer.sv | 66 ++++++
 rtl/sw_seq_streamer.sv | 222 ++++++++++++++++++++++
 tb/tb_sw_seq_streamer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman symbol streamer: frame codes,
// symbol encodings and the streamer FSM state type.
package sw_pkg;

  typedef enum logic [1:0] {
    RE_IDLE  = 2'b00,
    RE_QUERY = 2'b01,
    RE_DB    = 2'b10,
    RE_MARK  = 2'b11
  } sw_frame_e;

  typedef enum logic [1:0] {
    SYM_A = 2'b00,
    SYM_C = 2'b01,
    SYM_G = 2'b10,
    SYM_T = 2'b11
  } sw_sym_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SEND_Q,
    ST_SEND_D,
    ST_WAIT
  } sw_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_sym_buffer.sv
// Write-once-per-strobe symbol store with a length count and an asynchronous
// read port; writes past DEPTH are dropped and flagged for one cycle.
module sw_sym_buffer
  import sw_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [1:0]                 wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [1:0]                 rd_data_o,
  output logic [$clog2(DEPTH):0]     len_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          full;
  logic          wr_ok;

  assign full  = (wr_ptr_q == LEN_FULL);
  assign wr_ok = wr_en_i && !full && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      len_d    = '0;
    end else if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + LEN_ONE;
      len_d    = len_q + LEN_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
    end
  end

  // Storage is not reset; only entries below len_q are ever read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign len_o     = len_q;
  assign ovf_o     = wr_en_i && full && !clear_i;

endmodule

// File: rtl/sw_seq_streamer.sv
// Host-side streamer: buffers query/database symbols, frames them onto the
// core's Read_en/data_readin inputs, then waits for the core's score.
module sw_seq_streamer
  import sw_pkg::*;
#(
  parameter int QMAX        = 64,
  parameter int DMAX        = 256,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [1:0]  wr_data,
  input  logic        clear,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        overflow,
  output logic [15:0] result,
  output logic [1:0]  Read_en,
  output logic [1:0]  data_readin,
  input  logic        valid,
  input  logic [15:0] max_result
);

  // state  | meaning
  // IDLE   | outputs idle; host may write or clear buffers; waits for start
  // MARK   | start marker on Read_en
  // SEND_Q | query symbol idx_q on the bus
  // SEND_D | database symbol idx_q on the bus
  // WAIT   | stream finished; waiting for valid or the timeout count

  localparam int QAW = $clog2(QMAX);
  localparam int QLW = QAW + 1;
  localparam int DAW = $clog2(DMAX);
  localparam int DLW = DAW + 1;
  localparam int IW  = max2(QLW, DLW);
  localparam int WCW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [IW-1:0]  IDX_ONE = IW'(1);
  localparam logic [WCW-1:0] WC_ONE  = WCW'(1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT_CYC - 1);

  sw_state_e      state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [1:0]     re_q, re_d;
  logic [1:0]     data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    result_q, result_d;

  logic [QLW-1:0] q_len;
  logic [DLW-1:0] d_len;
  logic [1:0]     q_rd, d_rd;
  logic           q_ovf, d_ovf;
  logic [IW-1:0]  q_last, d_last;

  logic           in_idle;
  logic           start_go;
  logic           host_ok;
  logic           clr_en;
  logic           wr_eff;

  assign in_idle  = (state_q == ST_IDLE);
  // clear beats start; start beats a same-cycle write
  assign start_go = in_idle && start && !clear && (q_len != '0) && (d_len != '0);
  assign host_ok  = in_idle && !start_go;
  assign clr_en   = host_ok && clear;
  assign wr_eff   = host_ok && !clear && wr_en;

  assign q_last = IW'(q_len) - IDX_ONE;
  assign d_last = IW'(d_len) - IDX_ONE;

  sw_sym_buffer #(.DEPTH(QMAX)) u_qbuf (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (clr_en),
    .wr_en_i   (wr_eff && !wr_sel),
    .wr_data_i (wr_data),
    .rd_idx_i  (idx_d[QAW-1:0]),
    .rd_data_o (q_rd),
    .len_o     (q_len),
    .ovf_o     (q_ovf)
  );

  sw_sym_buffer #(.DEPTH(DMAX)) u_dbuf (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (clr_en),
    .wr_en_i   (wr_eff && wr_sel),
    .wr_data_i (wr_data),
    .rd_idx_i  (idx_d[DAW-1:0]),
    .rd_data_o (d_rd),
    .len_o     (d_len),
    .ovf_o     (d_ovf)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;

    if (clr_en) begin
      ovf_d = 1'b0;
    end else if (q_ovf || d_ovf) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d = ST_MARK;
          idx_d   = '0;
        end
      end
      ST_MARK: begin
        state_d = ST_SEND_Q;
        idx_d   = '0;
      end
      ST_SEND_Q: begin
        if (idx_q == q_last) begin
          state_d = ST_SEND_D;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_SEND_D: begin
        if (idx_q == d_last) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          wcnt_d  = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_WAIT: begin
        if (valid) begin
          state_d  = ST_IDLE;
          result_d = max_result;
          done_d   = 1'b1;
        end else if (wcnt_q == WC_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WC_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus contents are decoded from the next state so they register in step with it.
  always_comb begin
    re_d   = RE_IDLE;
    data_d = SYM_A;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_MARK: begin
        re_d = RE_MARK;
      end
      ST_SEND_Q: begin
        re_d   = RE_QUERY;
        data_d = q_rd;
      end
      ST_SEND_D: begin
        re_d   = RE_DB;
        data_d = d_rd;
      end
      default: begin
        re_d   = RE_IDLE;
        data_d = SYM_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      re_q      <= RE_IDLE;
      data_q    <= SYM_A;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      re_q      <= re_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign Read_en     = re_q;
  assign data_readin = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = ovf_q;
  assign result      = result_q;

endmodule

// File: tb/tb_sw_seq_streamer.sv
// Bench for sw_seq_streamer: queue-based timing model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sw_seq_streamer;

  localparam int QM = 8;
  localparam int DM = 16;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_sel = 1'b0, clear = 1'b0, start = 1'b0;
  logic [1:0]  wr_data = 2'b00;
  logic        valid = 1'b0;
  logic [15:0] max_result = 16'd0;
  logic        busy, done, timeout, overflow;
  logic [15:0] result;
  logic [1:0]  Read_en, data_readin;

  always #5 clk = ~clk;

  sw_seq_streamer #(.QMAX(QM), .DMAX(DM), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clear(clear), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .result(result), .Read_en(Read_en),
    .data_readin(data_readin), .valid(valid), .max_result(max_result)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  // reference model: edge-indexed arithmetic over snapshots of the buffers
  logic [1:0]  mq[$], md[$], rq[$], rdq[$];
  logic [1:0]  m_re = 0, m_data = 0;
  logic        m_busy = 0, m_done = 0, m_to = 0, m_ovf = 0;
  logic [15:0] m_result = 0;
  int          t0 = 0, nw = 0, k, nq, nd;

  int          core_delay = 0;
  logic [15:0] score = 0;
  bit          spur_en = 0;

  int marker_cnt = 0, qframe_cnt = 0, done_cnt = 0, to_cnt = 0;
  int last_done_cyc = -1, last_to_cyc = -1;
  logic [3:0] flog [0:8191];

  always @(posedge clk) begin
    cyc++;
    m_done = 0;
    m_to   = 0;
    if (rst) begin
      mq.delete(); md.delete();
      m_ovf = 0; m_result = 0; m_busy = 0; m_re = 0; m_data = 0;
    end else if (!m_busy) begin
      m_re = 0; m_data = 0;
      if (clear) begin
        mq.delete(); md.delete(); m_ovf = 0;
      end else if (start && mq.size() > 0 && md.size() > 0) begin
        t0 = cyc; rq = mq; rdq = md;
        nw = t0 + rq.size() + rdq.size() + 1;
        m_busy = 1; m_re = 2'b11;
      end else if (wr_en) begin
        if (wr_sel) begin
          if (md.size() < DM) md.push_back(wr_data); else m_ovf = 1;
        end else begin
          if (mq.size() < QM) mq.push_back(wr_data); else m_ovf = 1;
        end
      end
    end else begin
      k = cyc - t0; nq = rq.size(); nd = rdq.size();
      if (k <= nq) begin
        m_re = 2'b01; m_data = rq[k-1];
      end else if (k <= nq + nd) begin
        m_re = 2'b10; m_data = rdq[k-1-nq];
      end else begin
        m_re = 0; m_data = 0;
        if (k >= nq + nd + 2) begin
          if (valid) begin
            m_result = max_result; m_done = 1; m_busy = 0;
          end else if (cyc - nw == TO) begin
            m_to = 1; m_busy = 0;
          end
        end
      end
    end
  end

  // core stand-in: answers core_delay edges after WAIT entry, plus stray valids outside WAIT
  always @(negedge clk) begin
    if (m_busy && core_delay > 0 && (cyc + 1) == nw + core_delay) begin
      valid = 1; max_result = score;
    end else if (spur_en && !(m_busy && (cyc + 1) > nw) && $urandom_range(0, 7) == 0) begin
      valid = 1; max_result = 16'($urandom);
    end else begin
      valid = 0; max_result = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    n_chk++;
    if ({Read_en, data_readin, busy, done, timeout, overflow, result} !==
        {m_re, m_data, m_busy, m_done, m_to, m_ovf, m_result}) begin
      n_fail++;
      $display("FAIL cyc %0d outputs: dut re=%b d=%b busy=%b done=%b to=%b ovf=%b res=%0d, required re=%b d=%b busy=%b done=%b to=%b ovf=%b res=%0d",
               cyc, Read_en, data_readin, busy, done, timeout, overflow, result,
               m_re, m_data, m_busy, m_done, m_to, m_ovf, m_result);
    end
    if (Read_en == 2'b11) marker_cnt++;
    if (Read_en == 2'b01) qframe_cnt++;
    if (done)    begin done_cnt++; last_done_cyc = cyc; end
    if (timeout) begin to_cnt++;   last_to_cyc   = cyc; end
    if (cyc < 8192) flog[cyc] = {Read_en, data_readin};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input logic sel, input logic [1:0] s);
    wr_en = 1; wr_sel = sel; wr_data = s;
    tick();
    wr_en = 0;
  endtask

  task automatic pstart();
    start = 1; tick(); start = 0;
  endtask

  task automatic pclear();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || m_busy) && n < budget) begin
      tick(); n++;
    end
    check("wait_idle_in_budget", (n < budget), 1);
  endtask

  logic [3:0] exp2 [9];
  int t, d0, m0, q0, to0;

  initial begin
    exp2 = '{4'hC, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h0};

    // reset values
    tick(); tick();
    check("rst_read_en", Read_en, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    rst = 0;
    tick();

    // basic ACGT / ACG stream with stray valids before WAIT
    spur_en = 1;
    wr(0, 0); wr(0, 1); wr(0, 2); wr(0, 3);
    wr(1, 0); wr(1, 1); wr(1, 2);
    core_delay = 5; score = 16'd6;
    d0 = done_cnt; t = cyc + 1;
    pstart();
    check("busy_after_start", busy, 1);
    wait_idle(200);
    for (int i = 0; i < 9; i++) check($sformatf("basic_frame_%0d", i), flog[t+i], exp2[i]);
    check("basic_result", result, 6);
    check("basic_done_count", done_cnt - d0, 1);
    check("basic_done_cycle", last_done_cyc, t + 13);
    check("basic_busy_low", busy, 0);
    spur_en = 0;

    // empty query: start ignored
    pclear();
    wr(1, 2); wr(1, 1);
    m0 = marker_cnt; d0 = done_cnt;
    pstart();
    check("empty_q_busy", busy, 0);
    repeat (5) tick();
    check("empty_q_no_marker", marker_cnt - m0, 0);
    check("empty_q_no_done", done_cnt - d0, 0);

    // query overflow
    pclear();
    for (int i = 0; i < QM + 1; i++) wr(0, 2'(i));
    wr(1, 3);
    check("ovf_set", overflow, 1);
    q0 = qframe_cnt; core_delay = 2; score = 16'd77;
    pstart();
    wait_idle(200);
    check("ovf_query_frames", qframe_cnt - q0, QM);
    check("ovf_result", result, 77);
    pclear();
    check("ovf_cleared", overflow, 0);

    // timeout, then a fresh start is accepted
    wr(0, 1); wr(0, 2); wr(1, 3); wr(1, 0);
    core_delay = 0; to0 = to_cnt; t = cyc + 1;
    pstart();
    wait_idle(TO + 50);
    check("to_cycle", last_to_cyc, t + 5 + TO);
    check("to_count", to_cnt - to0, 1);
    check("to_result_kept", result, 77);
    core_delay = 3; score = 16'd9;
    pstart();
    check("restart_busy", busy, 1);
    wait_idle(200);
    check("restart_result", result, 9);

    // reset during SEND_D
    pclear();
    wr(0, 1); wr(0, 2); wr(0, 3);
    for (int i = 0; i < 6; i++) wr(1, 2'(i));
    core_delay = 4;
    pstart();
    repeat (5) tick();
    check("pre_rst_db_frame", Read_en, 2'b10);
    rst = 1; tick(); rst = 0;
    check("rst_mid_read_en", Read_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_result", result, 0);
    pstart();
    check("post_rst_start_ignored", busy, 0);

    // clear+start: clear wins
    wr(0, 1); wr(0, 2); wr(1, 3);
    clear = 1; start = 1; tick(); clear = 0; start = 0;
    check("clr_start_busy", busy, 0);
    pstart();
    check("clr_start_emptied", busy, 0);

    // start+write: start wins, write dropped
    wr(0, 3); wr(0, 0); wr(1, 1); wr(1, 2);
    core_delay = 2;
    start = 1; wr_en = 1; wr_sel = 0; wr_data = 2'b01;
    tick();
    start = 0; wr_en = 0;
    check("start_wr_busy", busy, 1);
    wait_idle(200);
    q0 = qframe_cnt;
    pstart();
    wait_idle(200);
    check("start_wr_qlen_kept", qframe_cnt - q0, 2);

    // randomized traffic
    spur_en = 1;
    repeat (3000) begin
      rst     = ($urandom_range(0, 399) == 0);
      clear   = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 19) == 0);
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_sel  = ($urandom_range(0, 1) == 1);
      wr_data = 2'($urandom_range(0, 3));
      if (!m_busy) begin
        core_delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
        score = 16'($urandom);
      end
      tick();
    end
    rst = 0; clear = 0; start = 0; wr_en = 0;
    wait_idle(TO + 200);
    spur_en = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
